sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single byte-wide SDRAM controller between two requesters:
  - the CPU register-mapped SDRAM port (`c_*`);
  - a DMA/video prefetch engine (`d_*`).
- Sequences each access as start → wait-for-ready → return data → acknowledge, then arbitrates round-robin.
- Adds a per-access timeout so a hung controller cannot stall the CPU.
- Sits between the CPU/DMA logic and the SDRAM controller, in the 25 MHz CPU clock domain.

Parameters:
- `AW`, 26, SDRAM byte address width (64 MB).
- `TIMEOUT`, 1024, WAIT-state cycles before an access is aborted.
- `CPU_PRIO`, 0, 0 = round-robin on contention; 1 = CPU always wins ties.

Ports:
- `clock` in 1: single clock for the block.
- `reset_n` in 1: asynchronous, active-low reset.
- `c_req` in 1: CPU request; level, held until `c_ack`.
- `c_we` in 1: CPU write enable (1 = write).
- `c_addr` in AW: CPU byte address.
- `c_wdata` in 8: CPU write data.
- `c_rdata` out 8: CPU read data; valid with `c_ack`, held until the next CPU ack.
- `c_ack` out 1: one-cycle completion pulse to the CPU.
- `d_req` in 1: DMA request; level, held until `d_ack`.
- `d_we` in 1: DMA write enable.
- `d_addr` in AW: DMA byte address.
- `d_wdata` in 8: DMA write data.
- `d_rdata` out 8: DMA read data; valid with `d_ack`.
- `d_ack` out 1: one-cycle completion pulse to the DMA.
- `sd_address` out AW: address to the SDRAM controller.
- `sd_we` out 1: write enable to the controller.
- `sd_data` out 8: write data to the controller.
- `sd_start` out 1: one-cycle command strobe.
- `sd_q` in 8: read data from the controller.
- `sd_ready` in 1: controller idle / data valid.
- `busy` out 1: high in every state except IDLE.
- `owner` out 1: current/last grant (0 = CPU, 1 = DMA).
- `timeout` out 1: one-cycle pulse, coincident with an ack that ended by timeout.

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0, except `owner` = 1 (DMA was "last", so the CPU wins the first tie).
  - `c_rdata` = `d_rdata` = 8'h00; `sd_*` = 0.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting:
    - `CPU_PRIO` = 1: grant CPU.
    - `CPU_PRIO` = 0: grant the port that is not `owner`.
  - On grant, in the same cycle:
    - register that port's addr/we/wdata into `sd_address`/`sd_we`/`sd_data`;
    - set `owner`;
    - drive `sd_start` = 1 for exactly one cycle;
    - go to ARM.
- ARM:
  - Exactly 1 cycle; `sd_ready` is ignored (the controller drops ready within 1 cycle of start).
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On `sd_ready` = 1:
    - latch `sd_q` into the granted port's rdata (reads and writes alike; write data is don't-care);
    - pulse that port's ack;
    - go to DONE.
  - If the counter reaches `TIMEOUT`-1 with ready still low:
    - load rdata = 8'hFF;
    - pulse ack and `timeout` together;
    - go to DONE.
  - Ready and timeout in the same cycle: ready wins and `timeout` stays 0.
- DONE:
  - 1 cycle, giving the requester time to drop or change `req`; then IDLE.
  - Minimum access = 4 cycles: IDLE-grant, ARM, WAIT, DONE.
- `sd_address`/`sd_we`/`sd_data` hold stable from the start strobe until the next grant.
- Requester inputs are sampled only at grant; changes afterwards are ignored.
- A requester that drops `req` before its ack still completes; the ack is issued and may be ignored.
- Never both acks in one cycle; never two `sd_start` pulses without an intervening ready or timeout.
- Asynchronous reset mid-access:
  - immediate return to IDLE with all outputs at reset values;
  - no ack is issued for the in-flight access.
- Timeout counter width = `$clog2(TIMEOUT)`; it saturates and never wraps.

Decomposition:
- Shared package `sdram_arb_pkg`:
  - state enum {IDLE, ARM, WAIT, DONE};
  - owner constants `OWN_CPU`=0, `OWN_DMA`=1;
  - `TIMEOUT_DATA` = 8'hFF.
- One natural sub-module: `rr_grant2`, the 2-way combinational round-robin/priority picker.
  - Inputs: `c_req`, `d_req`, `owner`, `CPU_PRIO`.
  - Outputs: `grant_valid`, `grant_id`.

Test Plan:
- CPU read alone:
  - stimulus: `c_req`=1, `c_addr`=26'h0000123, model returns ready 3 cycles after start with `sd_q`=8'hA5;
  - required: `sd_start` pulses once; `c_ack` on that ready cycle; `c_rdata`=8'hA5; `owner`=0; `busy` low 1 cycle later.
- Simultaneous requests, `CPU_PRIO`=0:
  - stimulus: both `req` held from reset for 4 accesses;
  - required: grant order CPU, DMA, CPU, DMA; ack count 2 each; never two acks in one cycle.
- `CPU_PRIO`=1 contention:
  - stimulus: both `req` held;
  - required: CPU granted every time and DMA gets 0 acks while the CPU requests; after the CPU drops, the next grant goes to DMA.
- DMA write:
  - stimulus: `d_we`=1, `d_addr`=26'h3FFFFFF, `d_wdata`=8'h5A, inputs changed after grant;
  - required: `sd_we`=1, `sd_address`=26'h3FFFFFF, `sd_data`=8'h5A held stable until `d_ack`.
- Timeout:
  - stimulus: `TIMEOUT`=16, model never raises ready after start;
  - required: `c_ack` and `timeout` together exactly 16 WAIT cycles after ARM; `c_rdata`=8'hFF; next request is served normally.
- Reset mid-WAIT:
  - stimulus: assert `reset_n`=0 while in WAIT;
  - required: outputs return to reset values asynchronously with no ack pulse; after release, a fresh CPU request completes normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic       OWN_CPU      = 1'b0;
  localparam logic       OWN_DMA      = 1'b1;
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester and SDRAM-controller buses seen by the arbiter; slave = arbiter side.
interface sdram_port_arbiter_if #(
  parameter int AW = 26
);

  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [7:0]    c_wdata;
  logic [7:0]    c_rdata;
  logic          c_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [7:0]    d_wdata;
  logic [7:0]    d_rdata;
  logic          d_ack;

  logic [AW-1:0] sd_address;
  logic          sd_we;
  logic [7:0]    sd_data;
  logic          sd_start;
  logic [7:0]    sd_q;
  logic          sd_ready;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  sd_q, sd_ready,
    output c_rdata, c_ack, d_rdata, d_ack,
    output sd_address, sd_we, sd_data, sd_start
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output sd_q, sd_ready,
    input  c_rdata, c_ack, d_rdata, d_ack,
    input  sd_address, sd_we, sd_data, sd_start
  );

endinterface

// File: rtl/rr_grant2.sv
// Combinational 2-way picker: round-robin against the last owner, or fixed CPU
// priority on ties when CPU_PRIO is set.
module rr_grant2
  import sdram_arb_pkg::*;
#(
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic c_req,
  input  logic d_req,
  input  logic owner,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = c_req | d_req;
    grant_id    = OWN_CPU;
    if (c_req && d_req) begin
      grant_id = CPU_PRIO ? OWN_CPU : ~owner;
    end else if (d_req) begin
      grant_id = OWN_DMA;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one byte-wide SDRAM controller between CPU and DMA: grant, start strobe,
// wait for ready (bounded by TIMEOUT), registered ack + rdata, one idle cycle.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW       = 26,
  parameter int TIMEOUT  = 1024,
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sdram_port_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 owner,
  output logic                 timeout
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          owner_q,    owner_d;
  logic [AW-1:0] sd_addr_q,  sd_addr_d;
  logic          sd_we_q,    sd_we_d;
  logic [7:0]    sd_data_q,  sd_data_d;
  logic          sd_start_q, sd_start_d;
  logic [7:0]    c_rdata_q,  c_rdata_d;
  logic [7:0]    d_rdata_q,  d_rdata_d;
  logic          c_ack_q,    c_ack_d;
  logic          d_ack_q,    d_ack_d;
  logic          timeout_q,  timeout_d;

  logic          grant_valid;
  logic          grant_id;
  logic          fin;
  logic [7:0]    rd_dat;

  rr_grant2 #(.CPU_PRIO(CPU_PRIO)) u_grant (
    .c_req       (bus.c_req),
    .d_req       (bus.d_req),
    .owner       (owner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    sd_addr_d  = sd_addr_q;
    sd_we_d    = sd_we_q;
    sd_data_d  = sd_data_q;
    sd_start_d = 1'b0;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;
    c_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    timeout_d  = 1'b0;
    fin        = 1'b0;
    rd_dat     = bus.sd_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d    = grant_id;
          sd_addr_d  = (grant_id == OWN_DMA) ? bus.d_addr  : bus.c_addr;
          sd_we_d    = (grant_id == OWN_DMA) ? bus.d_we    : bus.c_we;
          sd_data_d  = (grant_id == OWN_DMA) ? bus.d_wdata : bus.c_wdata;
          sd_start_d = 1'b1;
          state_d    = ARM;
        end
      end
      // The controller may still show ready while it latches the start; skip it.
      ARM: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.sd_ready) begin
          fin = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          fin       = 1'b1;
          rd_dat    = TIMEOUT_DATA;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (fin) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      if (owner_q == OWN_DMA) begin
        d_ack_d   = 1'b1;
        d_rdata_d = rd_dat;
      end else begin
        c_ack_d   = 1'b1;
        c_rdata_d = rd_dat;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_DMA;
      sd_addr_q  <= '0;
      sd_we_q    <= 1'b0;
      sd_data_q  <= 8'h00;
      sd_start_q <= 1'b0;
      c_rdata_q  <= 8'h00;
      d_rdata_q  <= 8'h00;
      c_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      sd_addr_q  <= sd_addr_d;
      sd_we_q    <= sd_we_d;
      sd_data_q  <= sd_data_d;
      sd_start_q <= sd_start_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
      c_ack_q    <= c_ack_d;
      d_ack_q    <= d_ack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.sd_address = sd_addr_q;
  assign bus.sd_we      = sd_we_q;
  assign bus.sd_data    = sd_data_q;
  assign bus.sd_start   = sd_start_q;
  assign bus.c_rdata    = c_rdata_q;
  assign bus.c_ack      = c_ack_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_ack      = d_ack_q;

  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: two arbiters (round-robin and CPU-priority, TIMEOUT=16) each
// driven by a small latency-programmable SDRAM controller model.
module tb_sdram_port_arbiter;

  logic clock;
  logic reset_n;
  logic busy0, owner0, to0;
  logic busy1, owner1, to1;

  int n_vec = 0;
  int n_bad = 0;

  int   lat0 = 2, lat1 = 2;
  int   mcnt0 = 0, mcnt1 = 0;
  bit   hang0 = 1'b0;
  logic [7:0] qv0 = 8'h00, qv1 = 8'h00;

  int   nca0 = 0, nda0 = 0, nst0 = 0, nca1 = 0, nda1 = 0, dual = 0;
  logic order0[$];

  sdram_port_arbiter_if #(.AW(26)) b0 ();
  sdram_port_arbiter_if #(.AW(26)) b1 ();

  sdram_port_arbiter #(.AW(26), .TIMEOUT(16), .CPU_PRIO(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(b0),
    .busy(busy0), .owner(owner0), .timeout(to0)
  );

  sdram_port_arbiter #(.AW(26), .TIMEOUT(16), .CPU_PRIO(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(b1),
    .busy(busy1), .owner(owner1), .timeout(to1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input bit sel, input string tag, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 100) begin
      @(negedge clock);
      cyc++;
      hit = sel ? (b1.c_ack | b1.d_ack) : (b0.c_ack | b0.d_ack);
    end
    chk({tag, "_ack_seen"}, {31'd0, hit}, 1);
  endtask

  // Controller model: drops ready right after a start, raises it lat cycles later.
  initial begin
    b0.sd_ready = 1'b1; b0.sd_q = 8'h00;
    b1.sd_ready = 1'b1; b1.sd_q = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (b0.sd_start) begin
        b0.sd_ready = 1'b0; mcnt0 = lat0;
      end else if (mcnt0 > 0) begin
        mcnt0--;
        if (mcnt0 == 0 && !hang0) begin b0.sd_ready = 1'b1; b0.sd_q = qv0; end
      end
      if (b1.sd_start) begin
        b1.sd_ready = 1'b0; mcnt1 = lat1;
      end else if (mcnt1 > 0) begin
        mcnt1--;
        if (mcnt1 == 0) begin b1.sd_ready = 1'b1; b1.sd_q = qv1; end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (b0.c_ack) nca0++;
      if (b0.d_ack) nda0++;
      if (b1.c_ack) nca1++;
      if (b1.d_ack) nda1++;
      if (b0.c_ack && b0.d_ack) dual++;
      if (b1.c_ack && b1.d_ack) dual++;
      if (b0.sd_start) begin nst0++; order0.push_back(owner0); end
    end
  end

  initial begin
    int cyc, st_base, ca_base, da_base, ord_base, unstable;
    bit hit;
    b0.c_req = 0; b0.c_we = 0; b0.c_addr = '0; b0.c_wdata = 0;
    b0.d_req = 0; b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = 0;
    b1.c_req = 0; b1.c_we = 0; b1.c_addr = '0; b1.c_wdata = 0;
    b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;

    @(negedge clock);
    chk("rst_busy",     busy0, 0);
    chk("rst_owner",    owner0, 1);
    chk("rst_owner1",   owner1, 1);
    chk("rst_timeout",  to0, 0);
    chk("rst_sd_start", b0.sd_start, 0);
    chk("rst_sd_addr",  b0.sd_address, 0);
    chk("rst_rdata",    {b0.c_rdata, b0.d_rdata}, 0);
    chk("rst_acks",     {b0.c_ack, b0.d_ack}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // CPU read alone
    lat0 = 3; qv0 = 8'hA5; b0.c_addr = 26'h0000123; b0.c_req = 1;
    #2 st_base = nst0;
    wait_ack(0, "cpu_rd", cyc);
    chk("cpu_rd_lat",   cyc, 5);
    chk("cpu_rd_acks",  {b0.c_ack, b0.d_ack}, 2'b10);
    chk("cpu_rd_rdata", b0.c_rdata, 8'hA5);
    chk("cpu_rd_owner", owner0, 0);
    chk("cpu_rd_addr",  b0.sd_address, 26'h0000123);
    chk("cpu_rd_to",    to0, 0);
    b0.c_req = 0;
    #2 chk("cpu_rd_starts", nst0 - st_base, 1);
    @(negedge clock);
    chk("cpu_rd_busy_off", busy0, 0);
    chk("cpu_rd_ack_pulse", b0.c_ack, 0);
    chk("cpu_rd_rdata_hold", b0.c_rdata, 8'hA5);

    // Contention from reset, round-robin
    reset_n = 1'b0;
    lat0 = 2; qv0 = 8'h3C; b0.c_req = 1; b0.d_req = 1;
    @(negedge clock);
    reset_n = 1'b1;
    #2 ord_base = order0.size(); ca_base = nca0; da_base = nda0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(0, "rr", cyc);
      chk("rr_lat", cyc, (i == 0) ? 4 : 5);
      chk("rr_acks", {b0.c_ack, b0.d_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    b0.c_req = 0; b0.d_req = 0;
    #2;
    for (int i = 0; i < 4; i++) chk("rr_order", {31'd0, order0[ord_base + i]}, i % 2);
    chk("rr_cpu_acks", nca0 - ca_base, 2);
    chk("rr_dma_acks", nda0 - da_base, 2);
    chk("rr_d_rdata",  b0.d_rdata, 8'h3C);

    // CPU priority
    lat1 = 2; qv1 = 8'hC3; b1.c_req = 1; b1.d_req = 1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1, "prio", cyc);
      chk("prio_acks", {b1.c_ack, b1.d_ack}, 2'b10);
    end
    b1.c_req = 0;
    wait_ack(1, "prio_dma", cyc);
    chk("prio_dma_acks",  {b1.c_ack, b1.d_ack}, 2'b01);
    chk("prio_dma_owner", owner1, 1);
    chk("prio_dma_rdata", b1.d_rdata, 8'hC3);
    b1.d_req = 0;

    // DMA write, inputs changed after grant
    lat0 = 4; b0.d_we = 1; b0.d_addr = 26'h3FFFFFF; b0.d_wdata = 8'h5A; b0.d_req = 1;
    @(negedge clock);
    chk("dw_start", b0.sd_start, 1);
    b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = 8'h00;
    unstable = 0; hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clock);
      if (b0.sd_address !== 26'h3FFFFFF || b0.sd_we !== 1'b1 || b0.sd_data !== 8'h5A) unstable++;
      if (b0.d_ack) hit = 1;
    end
    chk("dw_ack",      {31'd0, hit}, 1);
    chk("dw_unstable", unstable, 0);
    chk("dw_bus",      {b0.sd_we, b0.sd_address, b0.sd_data}, {1'b1, 26'h3FFFFFF, 8'h5A});
    chk("dw_owner",    owner0, 1);
    b0.d_req = 0;
    @(negedge clock);

    // Timeout, then ready on the last WAIT cycle, then a normal access
    hang0 = 1; b0.c_addr = 26'h0000200; b0.c_req = 1;
    wait_ack(0, "to", cyc);
    chk("to_lat",   cyc, 18);
    chk("to_pulse", {b0.c_ack, to0}, 2'b11);
    chk("to_rdata", b0.c_rdata, 8'hFF);
    b0.c_req = 0;
    @(negedge clock);
    chk("to_pulse_end", {to0, busy0}, 0);
    hang0 = 0; lat0 = 16; qv0 = 8'h96; b0.c_req = 1;
    wait_ack(0, "edge", cyc);
    chk("edge_lat",   cyc, 18);
    chk("edge_to",    {b0.c_ack, to0}, 2'b10);
    chk("edge_rdata", b0.c_rdata, 8'h96);
    b0.c_req = 0;
    @(negedge clock);
    lat0 = 2; qv0 = 8'h11; b0.c_req = 1;
    wait_ack(0, "post_to", cyc);
    chk("post_to_lat",   cyc, 4);
    chk("post_to_rdata", b0.c_rdata, 8'h11);
    b0.c_req = 0;
    @(negedge clock);

    // Reset in the middle of WAIT
    lat0 = 10; b0.c_req = 1;
    repeat (4) @(negedge clock);
    chk("mid_busy", busy0, 1);
    #2 ca_base = nca0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",  busy0, 0);
    chk("mid_rst_owner", owner0, 1);
    chk("mid_rst_bus",   {b0.sd_address, b0.sd_we, b0.sd_start}, 0);
    chk("mid_rst_rdata", b0.c_rdata, 8'h00);
    chk("mid_rst_ack",   {b0.c_ack, to0}, 0);
    b0.c_req = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (12) @(negedge clock);
    #2 chk("mid_rst_no_ack", nca0 - ca_base, 0);
    lat0 = 2; qv0 = 8'h77; b0.c_addr = 26'h0000045; b0.c_req = 1;
    wait_ack(0, "fresh", cyc);
    chk("fresh_lat",   cyc, 4);
    chk("fresh_rdata", b0.c_rdata, 8'h77);
    chk("fresh_addr",  b0.sd_address, 26'h0000045);
    b0.c_req = 0;
    @(negedge clock);

    #2 chk("dual_ack", dual, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
